ycc_block_former: RTL and testbench

//  Raster-to-block stage directly downstream of the RGB->YCrCb colour converter.
//  - Accepts one Y/Cr/Cb pixel per handshake in raster order.
//  - Buffers 8 image lines in ping-pong banks.
//  - Emits level-shifted (value-128, signed) 8x8 blocks, 4:4:4, to the DCT stage.
//  - Output order per block column: all 64 Y samples, then 64 Cb, then 64 Cr.

---
 rtl/jpeg_pkg.sv | 26 ++
 rtl/ycc_line_ram.sv | 34 +++
 rtl/ycc_block_former.sv | 196 +++++++++++++++++++
 tb/tb_ycc_block_former.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG front-end: block geometry, component codes,
// the read-FSM encoding of the block former and the level-shift helper.
package jpeg_pkg;

    localparam int BLK_N  = 8;
    localparam int BLK_SZ = 64;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam logic [7:0] LEVEL_SHIFT = 8'd128;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_SHOW  = 2'd2
    } rd_state_t;

    // Unsigned sample minus 128 as an 8-bit two's complement value; modulo-256
    // subtraction of 128 equals flipping the top bit, so no saturation exists.
    function automatic logic [7:0] level_shift(input logic [7:0] v);
        return v - LEVEL_SHIFT;
    endfunction

endpackage

// File: rtl/ycc_line_ram.sv
// Two-bank line store: one write port, one registered read port.
// Address = {bank, offset}, offset = row*IMG_WIDTH + col within the bank.
module ycc_line_ram #(
    parameter int IMG_WIDTH = 640,
    localparam int AW = $clog2(8 * IMG_WIDTH) + 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [23:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [23:0]   rdata
);

    localparam int DEPTH = 8 * IMG_WIDTH;

    logic [23:0] mem [2][DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[AW-1]][waddr[AW-2:0]] <= wdata;
        end
    end

    // Synchronous read port; rdata holds while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr[AW-1]][raddr[AW-2:0]];
        end
    end

endmodule

// File: rtl/ycc_block_former.sv
// Raster-to-block stage: collects 8 lines of Y/Cb/Cr into one of two banks and
// replays a full bank as level-shifted 8x8 blocks (Y, then Cb, then Cr per block
// column).
// Handshake: a transfer happens on a rising clk edge where valid && ready; a
// presented output holds stable until accepted; in_ready depends only on state.
module ycc_block_former
    import jpeg_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_y,
    input  logic [7:0] in_cr,
    input  logic [7:0] in_cb,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] out_comp,
    output logic       out_first,
    output logic       out_last
);

    localparam int OW = $clog2(BLK_N * IMG_WIDTH);
    localparam int AW = OW + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] BLK_LAST = COL_W'(IMG_WIDTH / BLK_N - 1);
    localparam logic [2:0]       ROW_LAST = 3'(BLK_N - 1);
    localparam logic [5:0]       S_LAST   = 6'(BLK_SZ - 1);

    // ---------------- write side ----------------
    logic [2:0]       wr_row;
    logic [COL_W-1:0] wr_col;
    logic             wbank;
    logic [1:0]       full;
    logic             wr_fire;
    logic             wr_done;
    logic [2:0]       row_eff;
    logic [COL_W-1:0] col_eff;
    logic [OW-1:0]    wr_off;

    assign in_ready = ~full[wbank];
    assign wr_fire  = in_valid & in_ready;
    // A start-of-frame pixel restarts the current bank at row 0, col 0.
    assign row_eff  = in_sof ? 3'd0 : wr_row;
    assign col_eff  = in_sof ? '0 : wr_col;
    assign wr_done  = wr_fire && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
    assign wr_off   = OW'(row_eff) * OW'(IMG_WIDTH) + OW'(col_eff);

    // Raster position and write bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_row <= 3'd0;
            wr_col <= '0;
            wbank  <= 1'b0;
        end else if (wr_fire) begin
            if (col_eff == COL_LAST) begin
                wr_col <= '0;
                wr_row <= row_eff + 3'd1;
            end else begin
                wr_col <= col_eff + COL_W'(1);
                wr_row <= row_eff;
            end
            if (wr_done) begin
                wbank <= ~wbank;
            end
        end
    end

    // ---------------- read side ----------------
    rd_state_t        rd_state;
    rd_state_t        rd_next;
    logic             rbank;
    logic [COL_W-1:0] rd_b;
    logic [1:0]       rd_c;
    logic [5:0]       rd_s;
    logic [COL_W-1:0] nxt_b;
    logic [1:0]       nxt_c;
    logic [5:0]       nxt_s;
    logic             rd_en;
    logic             rd_done;
    logic [OW-1:0]    rd_off;
    logic [23:0]      rd_data;
    logic [7:0]       sel;

    // Bank occupancy: writer fills one bank while the reader drains the other,
    // so a set and a clear in the same cycle always touch different bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            if (wr_done) full[wbank] <= 1'b1;
            if (rd_done) full[rbank] <= 1'b0;
        end
    end

    // Read FSM next state, cursor advance and RAM read enable. On an accept
    // the next sample is read straight away so SHOW sustains 1 sample/clk.
    always_comb begin
        rd_next = rd_state;
        nxt_b   = rd_b;
        nxt_c   = rd_c;
        nxt_s   = rd_s;
        rd_en   = 1'b0;
        rd_done = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (full[rbank]) rd_next = RD_FETCH;
            end
            RD_FETCH: begin
                rd_en   = 1'b1;
                rd_next = RD_SHOW;
            end
            RD_SHOW: begin
                if (out_ready) begin
                    nxt_s = rd_s + 6'd1;
                    if (rd_s == S_LAST) begin
                        if (rd_c == COMP_CR) begin
                            nxt_c = COMP_Y;
                            if (rd_b == BLK_LAST) begin
                                nxt_b   = '0;
                                rd_done = 1'b1;
                            end else begin
                                nxt_b = rd_b + COL_W'(1);
                            end
                        end else begin
                            nxt_c = rd_c + 2'd1;
                        end
                    end
                    if (rd_done) rd_next = RD_IDLE;
                    else         rd_en   = 1'b1;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Sample s of block column b sits at row s[5:3], column 8*b + s[2:0].
    assign rd_off = OW'(nxt_s[5:3]) * OW'(IMG_WIDTH) + OW'({nxt_b, nxt_s[2:0]});

    // Read FSM state, cursor and read bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rbank    <= 1'b0;
            rd_b     <= '0;
            rd_c     <= COMP_Y;
            rd_s     <= 6'd0;
        end else begin
            rd_state <= rd_next;
            rd_b     <= nxt_b;
            rd_c     <= nxt_c;
            rd_s     <= nxt_s;
            if (rd_done) rbank <= ~rbank;
        end
    end

    ycc_line_ram #(
        .IMG_WIDTH(IMG_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_fire),
        .waddr({wbank, wr_off}),
        .wdata({in_y, in_cb, in_cr}),
        .re   (rd_en),
        .raddr({rbank, rd_off}),
        .rdata(rd_data)
    );

    // Output presentation; everything reads zero unless a sample is shown.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'd0;
        out_comp  = COMP_Y;
        out_first = 1'b0;
        out_last  = 1'b0;
        sel       = 8'd0;
        if (rd_state == RD_SHOW) begin
            case (rd_c)
                COMP_Y:  sel = rd_data[23:16];
                COMP_CB: sel = rd_data[15:8];
                default: sel = rd_data[7:0];
            endcase
            out_valid = 1'b1;
            out_data  = level_shift(sel);
            out_comp  = rd_c;
            out_first = (rd_s == 6'd0);
            out_last  = (rd_s == S_LAST);
        end
    end

endmodule

// File: tb/tb_ycc_block_former.sv
// Bench for ycc_block_former: a 16-pixel-wide instance for most scenarios and an
// 8-pixel-wide instance for the continuous-throughput scenario. Expected samples
// come from a pixel-list model that reorders each completed 8-line bank.
module tb_ycc_block_former;

    localparam int W0 = 16;
    localparam int W1 = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic       in_valid  [2];
    logic       in_ready  [2];
    logic       in_sof    [2];
    logic [7:0] in_y      [2];
    logic [7:0] in_cr     [2];
    logic [7:0] in_cb     [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_data  [2];
    logic [1:0] out_comp  [2];
    logic       out_first [2];
    logic       out_last  [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_q [$];   // {comp, first, last, data}
    logic [23:0] pix_q [$];   // {y, cb, cr} of the bank being filled

    int ready_mode [2] = '{0, 0};
    int acc_tot    [2] = '{0, 0};
    int stall_base [2] = '{0, 0};
    bit abort = 1'b0;

    always #5 clk = ~clk;

    ycc_block_former #(.IMG_WIDTH(W0), .COL_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sof(in_sof[0]),
        .in_y(in_y[0]), .in_cr(in_cr[0]), .in_cb(in_cb[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_comp(out_comp[0]), .out_first(out_first[0]), .out_last(out_last[0])
    );

    ycc_block_former #(.IMG_WIDTH(W1), .COL_W(3)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sof(in_sof[1]),
        .in_y(in_y[1]), .in_cr(in_cr[1]), .in_cb(in_cb[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_comp(out_comp[1]), .out_first(out_first[1]), .out_last(out_last[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp_v, $time);
        end
    endtask

    // Scoreboard and reference model, sampled mid-cycle.
    initial begin : monitor
        logic [11:0] cur;
        logic [11:0] exp_s;
        logic [11:0] held_val [2];
        bit          held [2];
        int          w;
        logic [23:0] p;
        logic [7:0]  v;
        held[0] = 1'b0;
        held[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                pix_q.delete();
                held[0] = 1'b0;
                held[1] = 1'b0;
            end else begin
                for (int u = 0; u < 2; u++) begin
                    w = (u == 0) ? W0 : W1;
                    cur = {out_comp[u], out_first[u], out_last[u], out_data[u]};
                    if (held[u])
                        check_eq("hold_stable", {19'd0, out_valid[u], cur}, {19'd0, 1'b1, held_val[u]});
                    held[u]     = out_valid[u] && !out_ready[u];
                    held_val[u] = cur;
                    if (out_valid[u] && out_ready[u]) begin
                        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
                        check_eq("out_sample", {20'd0, cur}, {20'd0, exp_s});
                        acc_tot[u]++;
                    end
                    if (in_valid[u] && in_ready[u]) begin
                        if (in_sof[u]) pix_q.delete();
                        pix_q.push_back({in_y[u], in_cb[u], in_cr[u]});
                        if (pix_q.size() == 8 * w) begin
                            for (int b = 0; b < w / 8; b++)
                                for (int c = 0; c < 3; c++)
                                    for (int s = 0; s < 64; s++) begin
                                        p = pix_q[(s / 8) * w + 8 * b + (s % 8)];
                                        v = (c == 0) ? p[23:16] : (c == 1) ? p[15:8] : p[7:0];
                                        exp_q.push_back({2'(c), s == 0, s == 63, 8'(v - 8'd128)});
                                    end
                            pix_q.delete();
                        end
                    end
                end
            end
        end
    end

    // Downstream ready: 0 = always, 1 = random, 2 = accept two samples then stall.
    initial begin : ready_drv
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                case (ready_mode[u])
                    1:       out_ready[u] = ($urandom_range(0, 3) != 0);
                    2:       out_ready[u] = ((acc_tot[u] - stall_base[u]) < 2);
                    default: out_ready[u] = 1'b1;
                endcase
            end
        end
    end

    task automatic send_pix(input int u, input logic [7:0] y, input logic [7:0] cb,
                            input logic [7:0] cr, input bit sof);
        int t;
        t = 0;
        in_y[u] = y;
        in_cb[u] = cb;
        in_cr[u] = cr;
        in_sof[u] = sof;
        in_valid[u] = 1'b1;
        while (!in_ready[u] && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 4000) begin
            check_eq("in_ready_timeout", {31'd0, in_ready[u]}, 32'd1);
            abort = 1'b1;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 = Y ramp/neutral chroma, 1 = constant 255/0/128, 2 = random, 3 = Y ramp/~idx Cb/random Cr
    task automatic stream(input int u, input int n, input int kind, input int first_idx, input int sof_at);
        int idx;
        logic [7:0] y, cb, cr;
        for (int i = 0; i < n && !abort; i++) begin
            idx = first_idx + i;
            case (kind)
                0: begin y = 8'(idx); cb = 8'd128; cr = 8'd128; end
                1: begin y = 8'd255; cb = 8'd0; cr = 8'd128; end
                3: begin y = 8'(idx); cb = ~8'(idx); cr = 8'($urandom_range(0, 255)); end
                default: begin
                    y  = 8'($urandom_range(0, 255));
                    cb = 8'($urandom_range(0, 255));
                    cr = 8'($urandom_range(0, 255));
                end
            endcase
            send_pix(u, y, cb, cr, i == sof_at);
        end
        in_valid[u] = 1'b0;
        in_sof[u] = 1'b0;
    endtask

    task automatic drain(input int u, input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid[u]) && t < 8000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
        check_eq({tag, "_idle"}, {31'd0, out_valid[u]}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"},  {31'd0, in_ready[0]},  32'd1);
        check_eq({tag, "_out_valid"}, {31'd0, out_valid[0]}, 32'd0);
        check_eq({tag, "_out_data"},  {24'd0, out_data[0]},  32'd0);
        check_eq({tag, "_out_comp"},  {30'd0, out_comp[0]},  32'd0);
        check_eq({tag, "_out_first"}, {31'd0, out_first[0]}, 32'd0);
        check_eq({tag, "_out_last"},  {31'd0, out_last[0]},  32'd0);
    endtask

    initial begin : main
        int lat;
        int base;
        int t;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0;
            in_sof[u] = 1'b0;
            in_y[u] = 8'd0;
            in_cb[u] = 8'd0;
            in_cr[u] = 8'd0;
        end
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("idle");

        // 1: Y ramp with neutral chroma, plus bank-full to first-output latency
        stream(0, 128, 0, 0, 0);
        lat = 0;
        while (!out_valid[0] && lat < 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("t1_latency_le3", {31'd0, lat <= 3}, 32'd1);
        drain(0, "t1");

        // 2: constant components under random backpressure, 384 samples per bank
        base = acc_tot[0];
        ready_mode[0] = 1;
        stream(0, 256, 1, 0, -1);
        drain(0, "t2");
        ready_mode[0] = 0;
        check_eq("t2_sample_count", acc_tot[0] - base, 32'd768);

        // 3: stall after two samples while both banks fill
        base = acc_tot[0];
        stall_base[0] = acc_tot[0];
        ready_mode[0] = 2;
        stream(0, 256, 2, 0, -1);
        check_eq("t3_in_ready_low", {31'd0, in_ready[0]}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t3_in_ready_still_low", {31'd0, in_ready[0]}, 32'd0);
        check_eq("t3_out_valid_held", {31'd0, out_valid[0]}, 32'd1);
        check_eq("t3_two_accepted", acc_tot[0] - base, 32'd2);
        ready_mode[0] = 0;
        drain(0, "t3");
        check_eq("t3_sample_count", acc_tot[0] - base, 32'd768);

        // 4: start of frame at pixel 37 discards the partial fill
        stream(0, 37, 3, 0, -1);
        stream(0, 128, 3, 37, 0);
        drain(0, "t4");

        // 5: asynchronous reset in the middle of a block
        stream(0, 128, 2, 0, 0);
        base = acc_tot[0];
        t = 0;
        while ((acc_tot[0] - base) < 20 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("t5_reached_sample20", {31'd0, (acc_tot[0] - base) >= 20}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("t5_busy_before_reset", {31'd0, out_valid[0]}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check_idle_outputs("t5_async_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        stream(0, 128, 2, 0, 0);
        drain(0, "t5");

        // 6: 8-pixel-wide instance, continuous traffic over 10 banks
        base = acc_tot[1];
        stream(1, 640, 2, 0, 0);
        drain(1, "t6");
        check_eq("t6_sample_count", acc_tot[1] - base, 32'd1920);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d failed so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
